// File: rtl/ris_adder_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit add/subtract datapath among NREQ requesters.
// One operation in flight at a time: grant in IDLE, compute in EXEC, hold result in RESP.
module ris_adder_arbiter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_op,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  res_valid,
   output logic [WIDTH-1:0]      res_data,
   output logic                  res_carry,
   output logic [IDW-1:0]        res_id,
   input  logic                  res_ready,
   output logic                  busy
);

   localparam int unsigned SW = WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   grant_id;
   logic [IDW-1:0]   scan_idx;
   logic             grant_any;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             op_q;
   logic [IDW-1:0]   id_q;
   logic [SW-1:0]    sum;

   // Winner search starting at rr_ptr; IDW-bit index arithmetic wraps modulo NREQ
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx = rr_ptr + IDW'(k);
         if (!grant_any && req_valid[scan_idx]) begin
            grant_any = 1'b1;
            grant_id  = scan_idx;
         end
      end
   end

   // Accept strobe is combinational in IDLE and forced low while reset is asserted
   always_comb begin
      req_ready = '0;
      if (rst_n && (state == IDLE) && grant_any) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_any) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (res_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Subtract is a + ~b + 1, so the top bit is NOT-borrow
   always_comb begin
      if (op_q) begin
         sum = {1'b0, a_q} + {1'b0, ~b_q} + SW'(1);
      end else begin
         sum = {1'b0, a_q} + {1'b0, b_q};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 1'b0;
         id_q      <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_id    <= '0;
         busy      <= 1'b0;
      end else begin
         busy <= (state_next != IDLE);
         case (state)
            IDLE: begin
               if (grant_any) begin
                  a_q    <= req_a[grant_id*WIDTH +: WIDTH];
                  b_q    <= req_b[grant_id*WIDTH +: WIDTH];
                  op_q   <= req_op[grant_id];
                  id_q   <= grant_id;
                  rr_ptr <= grant_id + IDW'(1);
               end
            end
            EXEC: begin
               res_data  <= sum[WIDTH-1:0];
               res_carry <= sum[WIDTH];
               res_id    <= id_q;
               res_valid <= 1'b1;
            end
            RESP: begin
               if (res_ready) res_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ris_adder_arbiter.sv
// Self-checking bench for ris_adder_arbiter: directed steps with random operands,
// expected results from arithmetic on integers and a round-robin pointer model.
module tb_ris_adder_arbiter;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned IDW   = 2;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_op;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic                  res_valid;
   logic [WIDTH-1:0]      res_data;
   logic                  res_carry;
   logic [IDW-1:0]        res_id;
   logic                  res_ready;
   logic                  busy;

   int checks   = 0;
   int failures = 0;
   int rr_model = 0;

   ris_adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_carry (res_carry),
      .res_id    (res_id),
      .res_ready (res_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input int a, input int b, input logic op);
      req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
      req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
      req_op[i]               = op;
   endtask

   task automatic rand_req(input int i);
      set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom));
   endtask

   // Called at a negedge in IDLE with inputs already applied; walks grant, EXEC and RESP
   // (holding res_ready low for 'hold' RESP cycles) and returns at the next IDLE negedge.
   task automatic run_op(input string tag, input int hold, output int winner);
      int ai, bi, exp_d, exp_c, s;
      logic [WIDTH-1:0] d0;
      winner = -1;
      for (int k = 0; k < int'(NREQ); k++) begin
         if (winner < 0 && req_valid[(rr_model + k) % NREQ]) winner = (rr_model + k) % NREQ;
      end
      if (winner < 0) begin
         chk({tag, "_no_requester"}, 32'd0, 32'd1);
         return;
      end
      ai = int'(req_a[winner*WIDTH +: WIDTH]);
      bi = int'(req_b[winner*WIDTH +: WIDTH]);
      if (req_op[winner]) begin
         exp_d = (ai - bi + 256) % 256;
         exp_c = (ai >= bi) ? 1 : 0;
      end else begin
         s     = ai + bi;
         exp_d = s % 256;
         exp_c = (s > 255) ? 1 : 0;
      end
      #1;
      chk({tag, "_grant"}, 32'(req_ready), 32'(1) << winner);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      chk({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
      @(negedge clk);
      rr_model = (winner + 1) % NREQ;
      chk({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
      chk({tag, "_exec_valid"}, 32'(res_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(res_valid), 32'd1);
      chk({tag, "_data"}, 32'(res_data), 32'(exp_d));
      chk({tag, "_carry"}, 32'(res_carry), 32'(exp_c));
      chk({tag, "_id"}, 32'(res_id), 32'(winner));
      chk({tag, "_resp_ready"}, 32'(req_ready), 32'd0);
      d0 = WIDTH'(exp_d);
      res_ready = (hold == 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
         chk({tag, "_hold_data"}, 32'(res_data), 32'(d0));
         chk({tag, "_hold_id"}, 32'(res_id), 32'(winner));
         chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
         chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
         res_ready = (h == hold - 1);
      end
      @(negedge clk);
   endtask

   initial begin
      int w;
      rst_n     = 1'b0;
      req_valid = NREQ'($urandom);
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b0;

      // Reset with random requests present
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid = NREQ'($urandom);
         #1;
         chk("rst_ready", 32'(req_ready), 32'd0);
         chk("rst_valid", 32'(res_valid), 32'd0);
         chk("rst_data", 32'(res_data), 32'd0);
         chk("rst_carry", 32'(res_carry), 32'd0);
         chk("rst_id", 32'(res_id), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
      end
      @(negedge clk);
      req_valid = '0;
      rst_n     = 1'b1;
      rr_model  = 0;
      @(negedge clk);
      #1;
      chk("idle_no_req", 32'(req_ready), 32'd0);

      // Single add from requester 2
      @(negedge clk);
      req_valid = 4'b0100;
      set_req(2, 8'h7F, 8'h01, 1'b0);
      run_op("add_single", 0, w);

      // Wrap and subtract on requester 1
      req_valid = 4'b0010;
      set_req(1, 8'hFF, 8'h01, 1'b0);
      run_op("add_wrap", 0, w);
      set_req(1, 8'h05, 8'h07, 1'b1);
      run_op("sub_borrow", 0, w);
      set_req(1, 8'h07, 8'h05, 1'b1);
      run_op("sub_noborrow", 0, w);
      for (int n = 0; n < 6; n++) begin
         rand_req(1);
         run_op("rand_single", 0, w);
      end

      // Round-robin from a fresh reset with all requesters active
      rst_n = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      rr_model = 0;
      for (int i = 0; i < int'(NREQ); i++) rand_req(i);
      req_valid = '1;
      for (int n = 0; n < 6; n++) begin
         run_op("rr_all", 0, w);
         rand_req(w);
      end
      req_valid[2] = 1'b0;
      for (int n = 0; n < 4; n++) begin
         run_op("rr_drop2", 0, w);
         rand_req(w);
      end

      // Backpressure: result held five cycles with requesters 0 and 1 waiting
      req_valid = 4'b0011;
      run_op("bp_first", 5, w);
      rand_req(w);
      run_op("bp_next", 0, w);

      // Reset during EXEC discards the operation and returns the pointer to 0
      for (int i = 0; i < int'(NREQ); i++) rand_req(i);
      req_valid = 4'b0100;
      rr_model  = 0;
      #1;
      chk("rstx_grant", 32'(req_ready), 32'b0100);
      @(negedge clk);
      req_valid = '1;
      rst_n     = 1'b0;
      #1;
      chk("rstx_valid", 32'(res_valid), 32'd0);
      chk("rstx_busy", 32'(busy), 32'd0);
      chk("rstx_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rstx_valid_hold", 32'(res_valid), 32'd0);
      rst_n    = 1'b1;
      rr_model = 0;
      run_op("rstx_after", 0, w);
      chk("rstx_first_id", 32'(w), 32'd0);
      rand_req(w);
      run_op("rstx_second", 0, w);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
